// File: rtl/mult_seq_shift_add.sv
// -----------------------------------------------------------------------------
// mult_seq_shift_add
//
// Sequential unsigned shift-and-add multiplier. One partial product is folded
// into the accumulator per clock, so every product takes exactly W clocks
// regardless of operand values. The 2*W-bit product feeds the FMAC
// accumulate adder, which can stall this block through out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (release synchronised upstream)
//   in_valid   operands a/b are valid
//   in_ready   block can accept operands (high only in IDLE)
//   a          multiplicand, unsigned, W bits
//   b          multiplier, unsigned, W bits
//   out_valid  product p is valid (high only in DONE)
//   out_ready  downstream accepts p
//   p          product a*b, 2*W bits, meaningful only while out_valid=1
// -----------------------------------------------------------------------------
module mult_seq_shift_add #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p
);

  // Step counter must be able to hold W itself, hence ceil(log2(W+1)) bits.
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [2*W-1:0]  acc_r;
  logic [2*W-1:0]  mcand_r;
  logic [W-1:0]    mplier_r;
  logic [CW-1:0]   cnt_r;

  // State register; an async reset returns the block to IDLE at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; an unreachable encoding recovers to IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // No early exit on a zero multiplier: latency stays fixed at W.
        if (cnt_r == LAST_STEP) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Handshake outputs are pure decodes of the state register, so neither
  // depends combinationally on in_valid or out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: load operands on accept, one shift-and-add step per BUSY cycle,
  // hold everything otherwise so p stays stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            mcand_r  <= {{W{1'b0}}, a};
            mplier_r <= b;
            acc_r    <= '0;
            cnt_r    <= '0;
          end else begin
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            acc_r    <= acc_r;
            cnt_r    <= cnt_r;
          end
        end
        BUSY: begin
          // A W x W unsigned product fits in 2*W bits, so the add never carries out.
          if (mplier_r[0]) begin
            acc_r <= acc_r + mcand_r;
          end else begin
            acc_r <= acc_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          cnt_r    <= cnt_r + CW'(1);
        end
        default: begin
          acc_r    <= acc_r;
          mcand_r  <= mcand_r;
          mplier_r <= mplier_r;
          cnt_r    <= cnt_r;
        end
      endcase
    end
  end

  assign p = acc_r;

endmodule
